// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads instr_mem combinationally and buffers
// fetched words with their PCs in a small FIFO that feeds decode over valid/ready.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          PC_STEP    = 4,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             redirect_i,
    input  logic [15:0]      redirect_pc_i,
    output logic [15:0]      imem_addr_o,
    input  logic [15:0]      imem_instr_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [15:0]      instr_o,
    output logic [15:0]      instr_pc_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int          PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] PC_INC = 16'(PC_STEP);

    logic [15:0]      pc_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [15:0]      instr_mem_q [FIFO_DEPTH];
    logic [15:0]      pc_mem_q    [FIFO_DEPTH];
    logic             full;
    logic             pop;
    logic             push;

    // Redirect targets are word aligned, so the low address bits are dropped.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc_i[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign imem_addr_o   = pc_q;
    assign count_o       = count_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_mem_q[head_q];
    assign instr_pc_o    = pc_mem_q[head_q];

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = instr_valid_o & instr_ready_i;
    // A full buffer may still accept a fetch when decode drains the head this cycle.
    assign push = en_i & ~redirect_i & (~full | pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (redirect_i) begin
            // A coinciding pop was already taken by decode; the rest is flushed.
            pc_q    <= {redirect_pc_i[15:2], 2'b00};
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            if (push) begin
                instr_mem_q[tail_q] <= imem_instr_i;
                pc_mem_q[tail_q]    <= pc_q;
                tail_q              <= ptr_inc(tail_q);
                pc_q                <= pc_q + PC_INC;
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenario tasks plus a negedge scoreboard that
// queues each fetched {pc, word} and compares it when decode consumes it.
module tb_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    logic [15:0] imem [0:16383];
    logic [31:0] sb_q[$];
    logic [15:0] m_pc = 16'h0000;

    always #5 clk = ~clk;

    assign imem_instr = imem[imem_addr[15:2]];

    fetch_ctrl #(
        .RESET_PC  (16'h0000),
        .PC_STEP   (4),
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_addr_o  (imem_addr),
        .imem_instr_i (imem_instr),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .count_o      (count)
    );

    // Scoreboard: compare state, then advance the reference for the coming edge.
    always @(negedge clk) begin
        logic [31:0] exp;
        total++;
        if (int'(count) !== sb_q.size()) begin
            bad++;
            $display("[TB] FAIL sb_count: got %0d want %0d at %0t", count, sb_q.size(), $time);
        end
        total++;
        if (instr_valid !== (sb_q.size() != 0)) begin
            bad++;
            $display("[TB] FAIL sb_valid: got %0b want %0b at %0t", instr_valid, sb_q.size() != 0, $time);
        end
        total++;
        if (imem_addr !== m_pc) begin
            bad++;
            $display("[TB] FAIL sb_addr: got %h want %h at %0t", imem_addr, m_pc, $time);
        end
        if (rst) begin
            sb_q.delete();
            m_pc = 16'h0000;
        end else begin
            if (sb_q.size() != 0 && instr_ready) begin
                exp = sb_q.pop_front();
                total++;
                if ({instr_pc, instr} !== exp) begin
                    bad++;
                    $display("[TB] FAIL sb_pop: got pc=%h instr=%h want pc=%h instr=%h at %0t",
                             instr_pc, instr, exp[31:16], exp[15:0], $time);
                end
            end
            if (redirect) begin
                sb_q.delete();
                m_pc = {redirect_pc[15:2], 2'b00};
            end else if (en && sb_q.size() < DEPTH) begin
                sb_q.push_back({m_pc, imem[m_pc[15:2]]});
                m_pc = m_pc + 16'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b0;
        redirect_pc = 16'h0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b0;
        redirect_pc = 16'h0000;
        tick();
        tick();
        total++;
        if ({instr_valid, count, imem_addr, instr, instr_pc} !== 51'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: got v=%b c=%0d a=%h i=%h p=%h want all zero",
                     instr_valid, count, imem_addr, instr, instr_pc);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        en = 1'b1;
        instr_ready = 1'b1;
        total++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL stream_c0: got v=%b a=%h want v=0 a=0000", instr_valid, imem_addr);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(4 * (k - 1)) || instr !== imem[k - 1]
                || imem_addr !== 16'(4 * k) || count !== 2'd1) begin
                bad++;
                $display("[TB] FAIL stream_c%0d: got v=%b pc=%h i=%h a=%h c=%0d want v=1 pc=%h i=%h a=%h c=1",
                         k, instr_valid, instr_pc, instr, imem_addr, count,
                         16'(4 * (k - 1)), imem[k - 1], 16'(4 * k));
            end
            if (k <= 2) begin
                total++;
                if (instr !== ((k == 1) ? 16'h1298 : 16'h0850)) begin
                    bad++;
                    $display("[TB] FAIL stream_word%0d: got %h want %h", k, instr,
                             (k == 1) ? 16'h1298 : 16'h0850);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        en = 1'b1;
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (count > 2'd2) begin
                bad++;
                $display("[TB] FAIL bp_overflow: got count %0d want <= 2", count);
            end
        end
        total++;
        if (count !== 2'd2 || imem_addr !== 16'h0008 || instr_pc !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL bp_hold: got c=%0d a=%h pc=%h want c=2 a=0008 pc=0000",
                     count, imem_addr, instr_pc);
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(4 * k)) begin
                bad++;
                $display("[TB] FAIL bp_order%0d: got v=%b pc=%h want v=1 pc=%h",
                         k, instr_valid, instr_pc, 16'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        en = 1'b1;
        instr_ready = 1'b0;
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 16'h0031;
        tick();
        redirect = 1'b0;
        total++;
        if (count !== 2'd0 || instr_valid !== 1'b0 || imem_addr !== 16'h0030) begin
            bad++;
            $display("[TB] FAIL redir_flush: got c=%0d v=%b a=%h want c=0 v=0 a=0030",
                     count, instr_valid, imem_addr);
        end
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0030 || instr !== imem[12]) begin
            bad++;
            $display("[TB] FAIL redir_target: got v=%b pc=%h i=%h want v=1 pc=0030 i=%h",
                     instr_valid, instr_pc, instr, imem[12]);
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        en = 1'b1;
        instr_ready = 1'b0;
        tick();
        tick();
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || count !== 2'd2) begin
            bad++;
            $display("[TB] FAIL rpop_head: got v=%b pc=%h c=%0d want v=1 pc=0000 c=2",
                     instr_valid, instr_pc, count);
        end
        tick();
        redirect = 1'b0;
        total++;
        if (count !== 2'd0 || instr_valid !== 1'b0 || imem_addr !== 16'h0100) begin
            bad++;
            $display("[TB] FAIL rpop_flush: got c=%0d v=%b a=%h want c=0 v=0 a=0100",
                     count, instr_valid, imem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(16'h0100 + 4 * k)) begin
                bad++;
                $display("[TB] FAIL rpop_new%0d: got v=%b pc=%h want v=1 pc=%h",
                         k, instr_valid, instr_pc, 16'(16'h0100 + 4 * k));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        en = 1'b1;
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'hFFFD;
        tick();
        redirect = 1'b0;
        total++;
        if (imem_addr !== 16'hFFFC) begin
            bad++;
            $display("[TB] FAIL wrap_addr: got %h want fffc", imem_addr);
        end
        tick();
        total++;
        if (instr_pc !== 16'hFFFC || imem_addr !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL wrap_head0: got pc=%h a=%h want pc=fffc a=0000", instr_pc, imem_addr);
        end
        tick();
        total++;
        if (instr_pc !== 16'h0000 || instr_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wrap_head1: got pc=%h v=%b want pc=0000 v=1", instr_pc, instr_valid);
        end
        instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        total++;
        if (count !== 2'd2) begin
            bad++;
            $display("[TB] FAIL wrap_full: got count %0d want 2", count);
        end
    endtask

    task automatic test_en_low();
        do_reset();
        en = 1'b1;
        instr_ready = 1'b0;
        tick();
        tick();
        en = 1'b0;
        instr_ready = 1'b1;
        tick();
        total++;
        if (count !== 2'd1 || instr_pc !== 16'h0004 || imem_addr !== 16'h0008) begin
            bad++;
            $display("[TB] FAIL enlow_drain: got c=%0d pc=%h a=%h want c=1 pc=0004 a=0008",
                     count, instr_pc, imem_addr);
        end
        tick();
        tick();
        total++;
        if (count !== 2'd0 || instr_valid !== 1'b0 || imem_addr !== 16'h0008) begin
            bad++;
            $display("[TB] FAIL enlow_empty: got c=%0d v=%b a=%h want c=0 v=0 a=0008",
                     count, instr_valid, imem_addr);
        end
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        tick();
        total++;
        if (imem_addr !== 16'h0200 || instr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL enlow_redir: got a=%h v=%b want a=0200 v=0", imem_addr, instr_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        instr_ready = 1'b0;
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 16'h0300;
        tick();
        total++;
        if (imem_addr !== 16'h0300 || count !== 2'd0) begin
            bad++;
            $display("[TB] FAIL b2b_first: got a=%h c=%0d want a=0300 c=0", imem_addr, count);
        end
        redirect_pc = 16'h0404;
        tick();
        redirect = 1'b0;
        instr_ready = 1'b1;
        total++;
        if (imem_addr !== 16'h0404 || count !== 2'd0 || instr_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_second: got a=%h c=%0d v=%b want a=0404 c=0 v=0",
                     imem_addr, count, instr_valid);
        end
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0404) begin
            bad++;
            $display("[TB] FAIL b2b_head: got v=%b pc=%h want v=1 pc=0404", instr_valid, instr_pc);
        end
        tick();
        total++;
        if (instr_pc !== 16'h0408) begin
            bad++;
            $display("[TB] FAIL b2b_next: got pc=%h want 0408", instr_pc);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        instr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0500;
        total++;
        if (count !== 2'd2 || instr_valid !== 1'b1 || instr_pc !== 16'h0000 || imem_addr !== 16'h0008) begin
            bad++;
            $display("[TB] FAIL rstmid_before: got c=%0d v=%b pc=%h a=%h want c=2 v=1 pc=0000 a=0008",
                     count, instr_valid, instr_pc, imem_addr);
        end
        tick();
        rst = 1'b0;
        redirect = 1'b0;
        en = 1'b0;
        total++;
        if (count !== 2'd0 || instr_valid !== 1'b0 || imem_addr !== 16'h0000
            || instr !== 16'h0000 || instr_pc !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL rstmid_after: got c=%0d v=%b a=%h i=%h pc=%h want all zero",
                     count, instr_valid, imem_addr, instr, instr_pc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(3) != 0);
            instr_ready = ($urandom_range(2) != 0);
            redirect = ($urandom_range(15) == 0);
            redirect_pc = 16'($urandom);
            tick();
        end
        redirect = 1'b0;
        en = 1'b0;
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        total++;
        if (instr_valid !== 1'b0 || count !== 2'd0) begin
            bad++;
            $display("[TB] FAIL rand_drain: got v=%b c=%0d want v=0 c=0", instr_valid, count);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) imem[i] = 16'(i * 40503) ^ 16'hA5C3;
        imem[0] = 16'h1298;
        imem[1] = 16'h0850;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_pop();
        test_wrap();
        test_en_low();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
